vend_machine_param: RTL

VEND_MACHINE_PARAM -- requirements
Module: vend_machine_param

---
 rtl/vend_machine_param.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vend_machine_param.sv
// Parameterised coin-operated vending controller: synchronised coin input, credit FSM, change ejection.
// Optional stock counter with restock/sold_out is compiled in when VEND_STOCK_EN is defined.
module vend_machine_param #(
    parameter int PRICE       = 4,
    parameter int CREDIT_W    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STOCK_W     = 8,
    parameter int STOCK_INIT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
`ifdef VEND_STOCK_EN
    input  logic                restock,
    output logic                sold_out,
`endif
    output logic                pour_water,
    output logic                change1,
    output logic                change2,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);

    // Elaboration-time sanity checks on the parameter set.
    generate
        if (PRICE < 1 || PRICE > 64) begin : g_bad_price
            $error("PRICE must lie in 1..64");
        end
        if ((PRICE + 4) >= (2 ** CREDIT_W)) begin : g_bad_credit_w
            $error("CREDIT_W too narrow to hold PRICE+4");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if (STOCK_W < 1 || STOCK_INIT < 0 || STOCK_INIT >= (2 ** STOCK_W)) begin : g_bad_stock
            $error("STOCK_INIT does not fit in STOCK_W bits");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][1:0] sync_reg;
    logic [SYNC_STAGES-1:0]      fill_reg;
    logic [1:0]                  sync_out;
    logic                        prev_zero_reg;
    logic                        coin_evt_reg;
    logic [CREDIT_W-1:0]         coin_val_reg;
    logic [CREDIT_W-1:0]         coin_val_next;

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [CREDIT_W-1:0] coin_sum;
    logic [CREDIT_W-1:0] remain;
    logic                pour_reg, change1_reg, change2_reg, reject_reg;
    logic                pour_next, change1_next, change2_next, reject_next;
    logic                stock_empty;

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // fill_reg tracks when the synchroniser holds real samples again after reset,
    // so a code held through reset is not mistaken for a fresh insertion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
            fill_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], coin};
            fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        coin_val_next = '0;
        case (sync_out)
            2'd1:    coin_val_next = CREDIT_W'(1);
            2'd2:    coin_val_next = CREDIT_W'(2);
            2'd3:    coin_val_next = CREDIT_W'(5);
            default: coin_val_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_zero_reg <= 1'b0;
            coin_evt_reg  <= 1'b0;
            coin_val_reg  <= '0;
        end else begin
            coin_evt_reg <= 1'b0;
            if (fill_reg[SYNC_STAGES-1]) begin
                prev_zero_reg <= (sync_out == 2'd0);
                coin_evt_reg  <= prev_zero_reg && (sync_out != 2'd0);
            end
            coin_val_reg <= coin_val_next;
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stock_reg <= STOCK_W'(STOCK_INIT);
        end else if (restock) begin
            stock_reg <= STOCK_W'(STOCK_INIT);
        end else if (state_reg == VEND && stock_reg != '0) begin
            stock_reg <= stock_reg - 1'b1;
        end
    end

    assign stock_empty = (stock_reg == '0);
    assign sold_out    = stock_empty;
`else
    assign stock_empty = 1'b0;
`endif

    assign coin_sum = credit_reg + coin_val_reg;
    assign remain   = credit_reg - PRICE_C;

    // In CHANGE the credit is debited by whichever change pulse is on the wire this
    // cycle; a cycle spent on coin_reject ejects nothing, keeping pulses exclusive.
    always_comb begin
        state_next  = state_reg;
        credit_next = credit_reg;
        reject_next = 1'b0;
        case (state_reg)
            IDLE, COLLECT: begin
                if (coin_evt_reg) begin
                    if (state_reg == IDLE && stock_empty) begin
                        reject_next = 1'b1;
                    end else begin
                        credit_next = coin_sum;
                        if (coin_sum >= PRICE_C)
                            state_next = VEND;
                        else if (state_reg == COLLECT && cancel)
                            state_next = CHANGE;
                        else
                            state_next = COLLECT;
                    end
                end else if (state_reg == COLLECT && cancel) begin
                    state_next = CHANGE;
                end
            end
            VEND: begin
                reject_next = coin_evt_reg;
                credit_next = remain;
                state_next  = (remain != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_next = coin_evt_reg;
                if (change2_reg)
                    credit_next = credit_reg - TWO_C;
                else if (change1_reg)
                    credit_next = credit_reg - ONE_C;
                state_next = (credit_next == '0) ? IDLE : CHANGE;
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    assign pour_next    = (state_next == VEND);
    assign change2_next = (state_next == CHANGE) && !reject_next && (credit_next >= TWO_C);
    assign change1_next = (state_next == CHANGE) && !reject_next && (credit_next == ONE_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            credit_reg  <= '0;
            pour_reg    <= 1'b0;
            change1_reg <= 1'b0;
            change2_reg <= 1'b0;
            reject_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            credit_reg  <= credit_next;
            pour_reg    <= pour_next;
            change1_reg <= change1_next;
            change2_reg <= change2_next;
            reject_reg  <= reject_next;
        end
    end

    assign pour_water  = pour_reg;
    assign change1     = change1_reg;
    assign change2     = change2_reg;
    assign coin_reject = reject_reg;
    assign busy        = (state_reg == VEND) || (state_reg == CHANGE);
    assign credit      = credit_reg;

endmodule
